// File: rtl/conv_pkg.sv
// Shared constants and state codes for the convolution window sequencer.
// Provides default image/kernel sizes, derived widths and FSM state codes.
package conv_pkg;

    localparam int IMG_DEF = 6;
    localparam int K_DEF   = 3;
    localparam int OUT_DEF = IMG_DEF - K_DEF + 1;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ROW_IDX_W = idx_w(IMG_DEF);
    localparam int WIN_IDX_W = idx_w(OUT_DEF);
    localparam int CNT_W     = idx_w(IMG_DEF + 1);
    localparam int WIN_W     = K_DEF * K_DEF;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_SCAN  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for one switch-level control input.
// Ports: clk, rst (async high), sig (level in), rise (one-cycle pulse).
// With CONV_SEQ_SYNC_EN defined, sig first passes a 2-flop synchronizer.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic lvl;
    logic prev;

`ifdef CONV_SEQ_SYNC_EN
    logic s1;
    logic s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sig;
            s2 <= s1;
        end
    end

    assign lvl = s2;
`else
    assign lvl = sig;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= lvl;
    end

    assign rise = lvl & ~prev;

endmodule

// File: rtl/conv_window_sequencer.sv
// Captures a binary IMG x IMG image row by row, then streams every KxK
// window in raster order over a valid/ready handshake.
// Ports: clk, rst (async high), row_data/row_strobe (row capture),
//   start, clear, win_data/win_valid/win_ready/win_row/win_col,
//   rows_loaded, busy, done.
// Macro CONV_SEQ_SYNC_EN adds 2-flop synchronizers on control inputs.
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int IMG = IMG_DEF,
    parameter int K   = K_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IMG-1:0]               row_data,
    input  logic                         row_strobe,
    input  logic                         start,
    input  logic                         clear,
    output logic [K*K-1:0]               win_data,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic [idx_w(IMG-K+1)-1:0]    win_row,
    output logic [idx_w(IMG-K+1)-1:0]    win_col,
    output logic [idx_w(IMG+1)-1:0]      rows_loaded,
    output logic                         busy,
    output logic                         done
);

    localparam int NOUT = IMG - K + 1;
    localparam int RW   = idx_w(IMG);
    localparam int WW   = idx_w(NOUT);
    localparam int CW   = idx_w(IMG + 1);

    logic [1:0]     state;
    logic [IMG-1:0] img [IMG];
    logic [WW-1:0]  row_q;
    logic [WW-1:0]  col_q;
    logic [CW-1:0]  cnt_q;
    logic [K*K-1:0] win_raw;

    logic strobe_rise;
    logic start_rise;
    logic clr_rise;
    logic hs;
    logic last_col;
    logic last_row;

    rise_detect u_strobe (
        .clk  (clk),
        .rst  (rst),
        .sig  (row_strobe),
        .rise (strobe_rise)
    );

    rise_detect u_start (
        .clk  (clk),
        .rst  (rst),
        .sig  (start),
        .rise (start_rise)
    );

    rise_detect u_clear (
        .clk  (clk),
        .rst  (rst),
        .sig  (clear),
        .rise (clr_rise)
    );

    assign hs       = win_valid & win_ready;
    assign last_col = (col_q == WW'(NOUT - 1));
    assign last_row = (row_q == WW'(NOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
            cnt_q <= '0;
            row_q <= '0;
            col_q <= '0;
            for (int i = 0; i < IMG; i++) img[i] <= '0;
        end else if (clr_rise) begin
            // Image kept; rows get overwritten on reload.
            state <= ST_LOAD;
            cnt_q <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    if (strobe_rise) begin
                        img[RW'(cnt_q)] <= row_data;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(IMG - 1))
                            state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (start_rise) begin
                        state <= ST_SCAN;
                        row_q <= '0;
                        col_q <= '0;
                    end
                end
                ST_SCAN: begin
                    if (hs) begin
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                row_q <= '0;
                                state <= ST_DONE;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (start_rise) begin
                        state <= ST_SCAN;
                        row_q <= '0;
                        col_q <= '0;
                    end
                end
            endcase
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_r
        for (genvar c = 0; c < K; c++) begin : g_c
            logic [RW-1:0] pr;
            logic [RW-1:0] pc;
            assign pr = RW'(row_q) + RW'(r);
            assign pc = RW'(col_q) + RW'(c);
            assign win_raw[r*K+c] = img[pr][pc];
        end
    end

    assign win_valid   = (state == ST_SCAN);
    assign busy        = (state == ST_SCAN);
    assign done        = (state == ST_DONE);
    assign win_data    = win_valid ? win_raw : '0;
    assign win_row     = row_q;
    assign win_col     = col_q;
    assign rows_loaded = cnt_q;

endmodule
